// File: rtl/gf180mcu_osu_sc_12t_dlat_bist.sv
// BIST sequencer for the 12T transparent-high D-latch: drives LD/LE from an LFSR
// pattern, checks LQ for transparency and opacity, and reports errors and pass/fail.
module gf180mcu_osu_sc_12t_dlat_bist #(
    parameter int N_VEC = 256,
    parameter int ERR_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             LD,
    output logic             LE,
    input  logic             LQ,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERRCNT,
    output logic [15:0]      VECCNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_OPEN,
        S_HOLD,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [15:0]      N_VEC_W = 16'(N_VEC);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [15:0]      vec_q, vec_d;
    logic             ld_q, ld_d;
    logic             le_q, le_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             start_run;
    logic             last_vec;
    logic             mismatch;
    logic [7:0]       lfsr_next;

    assign start_run = START && (state_q == S_IDLE || state_q == S_DONE);
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign last_vec  = (vec_q + 16'd1) == N_VEC_W;
    // LQ is compared on the edges leaving OPEN (transparency) and CHECK (opacity).
    assign mismatch  = (state_q == S_OPEN || state_q == S_CHECK) && (LQ != lfsr_q[0]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_SETUP;
            S_SETUP: state_d = S_OPEN;
            S_OPEN:  state_d = S_HOLD;
            S_HOLD:  state_d = S_CHECK;
            S_CHECK: state_d = last_vec ? S_DONE : S_SETUP;
            S_DONE:  if (START) state_d = S_SETUP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lfsr_d = lfsr_q;
        vec_d  = vec_q;
        err_d  = err_q;
        if (start_run) begin
            lfsr_d = 8'h01;
            vec_d  = 16'd0;
            err_d  = '0;
        end else begin
            if (mismatch && err_q != ERR_MAX) begin
                err_d = err_q + 1'b1;
            end
            if (state_q == S_CHECK) begin
                lfsr_d = lfsr_next;
                vec_d  = vec_q + 16'd1;
            end
        end
    end

    // Outputs are decoded from the next state so every one of them leaves a flop.
    always_comb begin
        ld_d   = 1'b0;
        le_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        pass_d = 1'b0;
        case (state_d)
            S_SETUP, S_HOLD: begin
                ld_d   = lfsr_d[0];
                busy_d = 1'b1;
            end
            S_OPEN: begin
                ld_d   = lfsr_d[0];
                le_d   = 1'b1;
                busy_d = 1'b1;
            end
            S_CHECK: begin
                ld_d   = ~lfsr_d[0];
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                pass_d = (err_d == '0);
            end
            default: begin
                ld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr_q <= 8'h01;
            vec_q  <= 16'd0;
            err_q  <= '0;
            ld_q   <= 1'b0;
            le_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            vec_q  <= vec_d;
            err_q  <= err_d;
            ld_q   <= ld_d;
            le_q   <= le_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign LD     = ld_q;
    assign LE     = le_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign PASS   = pass_q;
    assign ERRCNT = err_q;
    assign VECCNT = vec_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_dlat_bist.sv
// Bench for the latch BIST: two instances (8-bit and 2-bit error counters) against
// ideal, stuck-at-0 and always-transparent latch models, checked against a timing model.
module tb_gf180mcu_osu_sc_12t_dlat_bist;

    localparam int NV          = 5;
    localparam int MODE_IDEAL  = 0;
    localparam int MODE_STUCK0 = 1;
    localparam int MODE_TIED   = 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;

    logic        ld_a, le_a, busy_a, done_a, pass_a, lq_a;
    logic [7:0]  err_a;
    logic [15:0] vec_a;
    logic        ld_b, le_b, busy_b, done_b, pass_b, lq_b;
    logic [1:0]  err_b;
    logic [15:0] vec_b;
    logic        latch_a = 1'b0;
    logic        latch_b = 1'b0;

    int          lq_mode     = MODE_IDEAL;
    int          n_compared  = 0;
    int          n_failed    = 0;
    bit          checking    = 1'b0;
    bit          e_tab [NV];

    bit          m_run  = 1'b0;
    int          m_c    = 0;
    int          m_mode = MODE_IDEAL;

    gf180mcu_osu_sc_12t_dlat_bist #(.N_VEC(NV), .ERR_W(8)) dut (
        .CLK(clk), .RST(rst), .START(start), .LD(ld_a), .LE(le_a), .LQ(lq_a),
        .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERRCNT(err_a), .VECCNT(vec_a)
    );

    gf180mcu_osu_sc_12t_dlat_bist #(.N_VEC(NV), .ERR_W(2)) dut_sat (
        .CLK(clk), .RST(rst), .START(start), .LD(ld_b), .LE(le_b), .LQ(lq_b),
        .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERRCNT(err_b), .VECCNT(vec_b)
    );

    always #5 clk = ~clk;

    // Ideal transparent-high latch for each instance.
    always @(le_a or ld_a) if (le_a) latch_a = ld_a;
    always @(le_b or ld_b) if (le_b) latch_b = ld_b;

    assign lq_a = (lq_mode == MODE_IDEAL) ? latch_a : (lq_mode == MODE_STUCK0) ? 1'b0 : ld_a;
    assign lq_b = (lq_mode == MODE_IDEAL) ? latch_b : (lq_mode == MODE_STUCK0) ? 1'b0 : ld_b;

    // Run tracker: m_c is the number of edges since the START-sampling edge T0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0;
            m_c   <= 0;
        end else if (start && (!m_run || m_c >= 4 * NV)) begin
            m_run  <= 1'b1;
            m_c    <= 0;
            m_mode <= lq_mode;
        end else if (m_run) begin
            m_c <= m_c + 1;
        end
    end

    // Failed samples taken at or before edge T0+c, saturated at emax.
    function automatic int exp_err(input int c, input int mode, input int emax);
        int n = 0;
        for (int k = 0; k < NV; k++) begin
            bit e     = e_tab[k];
            bit t_lq  = (mode == MODE_STUCK0) ? 1'b0 : e;
            bit o_lq  = (mode == MODE_IDEAL) ? e : (mode == MODE_STUCK0) ? 1'b0 : !e;
            if (4 * k + 2 <= c && t_lq != e) n++;
            if (4 * k + 4 <= c && o_lq != e) n++;
        end
        return (n > emax) ? emax : n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkDut(input string tag, input logic ld, input logic le, input logic busy,
                            input logic done, input logic pass, input int err, input int vec,
                            input int emax);
        int e_ld = 0, e_le = 0, e_busy = 0, e_done = 0, e_pass = 0, e_err = 0, e_vec = 0;
        if (m_run && m_c < 4 * NV) begin
            e_ld   = ((m_c % 4) == 3) ? int'(!e_tab[m_c / 4]) : int'(e_tab[m_c / 4]);
            e_le   = ((m_c % 4) == 1) ? 1 : 0;
            e_busy = 1;
            e_vec  = m_c / 4;
            e_err  = exp_err(m_c, m_mode, emax);
        end else if (m_run) begin
            e_done = 1;
            e_vec  = NV;
            e_err  = exp_err(m_c, m_mode, emax);
            e_pass = (e_err == 0) ? 1 : 0;
        end
        checkOutput({tag, ".LD"},     32'(ld),   32'(e_ld));
        checkOutput({tag, ".LE"},     32'(le),   32'(e_le));
        checkOutput({tag, ".BUSY"},   32'(busy), 32'(e_busy));
        checkOutput({tag, ".DONE"},   32'(done), 32'(e_done));
        checkOutput({tag, ".PASS"},   32'(pass), 32'(e_pass));
        checkOutput({tag, ".ERRCNT"}, 32'(err),  32'(e_err));
        checkOutput({tag, ".VECCNT"}, 32'(vec),  32'(e_vec));
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkDut("a", ld_a, le_a, busy_a, done_a, pass_a, int'(err_a), int'(vec_a), 255);
            checkDut("b", ld_b, le_b, busy_b, done_b, pass_b, int'(err_b), int'(vec_b), 3);
        end
    end

    // Leaves the bench at the negedge following T0.
    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int mode, input int repulse_at, input int exp_a,
                                 input int exp_b, input int exp_pass);
        logic [31:0] le_mask = '0;
        logic [7:0]  ld_bits = '0;
        lq_mode = mode;
        pulseStart();
        checkOutput("run_start.BUSY",   32'(busy_a), 32'd1);
        checkOutput("run_start.DONE",   32'(done_a), 32'd0);
        checkOutput("run_start.ERRCNT", 32'(err_a),  32'd0);
        checkOutput("run_start.VECCNT", 32'(vec_a),  32'd0);
        for (int c = 1; c <= 4 * NV; c++) begin
            @(negedge clk);
            start = (repulse_at > 0 && c == repulse_at - 1);
            le_mask[c] = le_a;
            if (le_a) ld_bits[(c - 1) / 4] = ld_a;
            if (c == 4 * NV - 1) checkOutput("done_not_early", 32'(done_a), 32'd0);
        end
        start = 1'b0;
        checkOutput("le_pattern",    le_mask,      32'h0002_2222);
        checkOutput("ld_at_le",      32'(ld_bits), 32'b1_0001);
        checkOutput("final.DONE",    32'(done_a),  32'd1);
        checkOutput("final.BUSY",    32'(busy_a),  32'd0);
        checkOutput("final.VECCNT",  32'(vec_a),   32'd5);
        checkOutput("final.ERRCNT",  32'(err_a),   32'(exp_a));
        checkOutput("final.PASS",    32'(pass_a),  32'(exp_pass));
        checkOutput("sat.ERRCNT",    32'(err_b),   32'(exp_b));
        checkOutput("sat.PASS",      32'(pass_b),  32'(exp_pass));
    endtask

    initial begin
        logic [7:0] lfsr = 8'h01;
        for (int k = 0; k < NV; k++) begin
            e_tab[k] = lfsr[0];
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        checkOutput("model.e_tab", {27'd0, e_tab[4], e_tab[3], e_tab[2], e_tab[1], e_tab[0]}, 32'b1_0001);
        checkOutput("model.stuck_err", 32'(exp_err(1000, MODE_STUCK0, 255)), 32'd4);
        checkOutput("model.tied_err",  32'(exp_err(1000, MODE_TIED, 255)),   32'd5);
        checkOutput("model.sat_err",   32'(exp_err(1000, MODE_STUCK0, 3)),   32'd3);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset.LD",     32'(ld_a),   32'd0);
        checkOutput("reset.LE",     32'(le_a),   32'd0);
        checkOutput("reset.BUSY",   32'(busy_a), 32'd0);
        checkOutput("reset.DONE",   32'(done_a), 32'd0);
        checkOutput("reset.PASS",   32'(pass_a), 32'd0);
        checkOutput("reset.ERRCNT", 32'(err_a),  32'd0);
        checkOutput("reset.VECCNT", 32'(vec_a),  32'd0);
        rst = 1'b0;
        checking = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(MODE_IDEAL, 7, 0, 0, 1);
        applyStimulus(MODE_STUCK0, 0, 4, 3, 0);
        applyStimulus(MODE_TIED, 0, 5, 3, 0);
        applyStimulus(MODE_IDEAL, 0, 0, 0, 1);

        lq_mode = MODE_STUCK0;
        pulseStart();
        repeat (9) @(negedge clk);
        checkOutput("abort.LE_before",     32'(le_a),  32'd1);
        checkOutput("abort.ERRCNT_before", 32'(err_a), 32'd2);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort.LE",     32'(le_a),   32'd0);
        checkOutput("abort.BUSY",   32'(busy_a), 32'd0);
        checkOutput("abort.ERRCNT", 32'(err_a),  32'd0);
        checkOutput("abort.VECCNT", 32'(vec_a),  32'd0);
        checkOutput("abort.DONE",   32'(done_a), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_abort.BUSY", 32'(busy_a), 32'd0);
        applyStimulus(MODE_IDEAL, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
